// File: rtl/pp_bank_writer.sv
`default_nettype none
// ============================================================================
//  Module   : pp_bank_writer (with package top_pkg)
//  Purpose  : Write-side sequencer for the attention ping-pong buffer. Each
//             accepted input beat of TOTAL_MODULES slices is serialised into
//             one port-A write per cycle on the active bank. A bank that holds
//             TOTAL_DEPTH words is marked full and handed to the consumer.
//             Writing then moves to the other bank. A bank is refilled only
//             after the consumer releases it with rd_release.
//  Ports    : clk, rst_n (synchronous, active-low)
//             in_valid / in_ready / in_data      input beat handshake
//             bank{0,1}_ena/_wea/_addra/_dina   registered port-A writes
//             bank_full[1:0]                    bank b readable by consumer
//             rd_release[1:0]                   consumer done with bank b
//             active_bank_wr                    bank currently being filled
//             err                               sticky protocol error
//  Options  : PP_WR_ERR_CHECK_EN -- when defined, builds the protocol checker
//             that drives err. Otherwise err is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================

package top_pkg;
   localparam int TOP_CHUNK_SIZE = 4;
endpackage

module pp_bank_writer #(
   parameter int WIDTH         = 16,
   parameter int NUM_CORES_A   = 2,
   parameter int NUM_CORES_B   = 1,
   parameter int TOTAL_MODULES = 4,
   parameter int COL_X         = 16,
   parameter int TOTAL_INPUT_W = 2,
   parameter int CHUNK_SIZE    = top_pkg::TOP_CHUNK_SIZE,
   parameter int MODULE_WIDTH  = WIDTH * CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B,
   parameter int IN_WIDTH      = MODULE_WIDTH * TOTAL_MODULES,
   parameter int TOTAL_DEPTH   = COL_X * TOTAL_INPUT_W,
   parameter int ADDR_WIDTH    = $clog2(TOTAL_DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [IN_WIDTH-1:0]     in_data,
   output logic                    bank0_ena,
   output logic                    bank0_wea,
   output logic [ADDR_WIDTH-1:0]   bank0_addra,
   output logic [MODULE_WIDTH-1:0] bank0_dina,
   output logic                    bank1_ena,
   output logic                    bank1_wea,
   output logic [ADDR_WIDTH-1:0]   bank1_addra,
   output logic [MODULE_WIDTH-1:0] bank1_dina,
   output logic [1:0]              bank_full,
   input  logic [1:0]              rd_release,
   output logic                    active_bank_wr,
   output logic                    err
);

   localparam int                    K_WIDTH   = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1;
   localparam logic [K_WIDTH-1:0]    K_LAST    = K_WIDTH'(TOTAL_MODULES - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(TOTAL_DEPTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SER   = 2'd1;
   localparam logic [1:0] S_STALL = 2'd2;

   generate
      if ((TOTAL_DEPTH % TOTAL_MODULES) != 0) begin : g_depth_check
         $error("pp_bank_writer: TOTAL_DEPTH must be a multiple of TOTAL_MODULES");
      end
   endgenerate

   logic [1:0]              state;
   logic [K_WIDTH-1:0]      k;
   logic [ADDR_WIDTH-1:0]   wr_ptr;       // address written this cycle while in SER
   logic [IN_WIDTH-1:0]     data_sr;      // slice k sits in the low MODULE_WIDTH bits
   logic [IN_WIDTH-1:0]     data_shifted;
   logic                    accept;
   logic                    last_slice;
   logic                    bank_done;
   logic                    other_bank;
   logic [1:0]              full_next;
   logic                    wr_en_next;
   logic [ADDR_WIDTH-1:0]   wr_addr_next;
   logic [MODULE_WIDTH-1:0] wr_data_next;

   assign in_ready     = rst_n && (state == S_IDLE) && !bank_full[active_bank_wr];
   assign accept       = in_valid && in_ready;
   assign data_shifted = data_sr >> MODULE_WIDTH;
   assign last_slice   = (state == S_SER) && (k == K_LAST);
   assign bank_done    = last_slice && (wr_ptr == ADDR_LAST);
   assign other_bank   = ~active_bank_wr;

   // A release and a fill completing on the other bank in the same cycle must
   // both land. Clearing an already-clear bit is harmless, so a bad release
   // has no effect on bank_full.
   always_comb begin
      full_next = bank_full & ~rd_release;
      if (bank_done) begin
         full_next[active_bank_wr] = 1'b1;
      end
   end

   // Next-cycle write. The bank outputs are registered, so the write for
   // cycle T+1 is prepared here at edge T. Slice 0 comes straight from the
   // input beat and later slices come from the shift register.
   always_comb begin
      wr_en_next   = 1'b0;
      wr_addr_next = '0;
      wr_data_next = '0;
      if (accept) begin
         wr_en_next   = 1'b1;
         wr_addr_next = wr_ptr;
         wr_data_next = in_data[MODULE_WIDTH-1:0];
      end else if ((state == S_SER) && !last_slice) begin
         wr_en_next   = 1'b1;
         wr_addr_next = wr_ptr + 1'b1;
         wr_data_next = data_shifted[MODULE_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         k              <= '0;
         wr_ptr         <= '0;
         bank_full      <= 2'b00;
         active_bank_wr <= 1'b0;
         bank0_ena      <= 1'b0;
         bank0_wea      <= 1'b0;
         bank0_addra    <= '0;
         bank0_dina     <= '0;
         bank1_ena      <= 1'b0;
         bank1_wea      <= 1'b0;
         bank1_addra    <= '0;
         bank1_dina     <= '0;
      end else begin
         bank_full   <= full_next;

         bank0_ena   <= wr_en_next && !active_bank_wr;
         bank0_wea   <= wr_en_next && !active_bank_wr;
         bank0_addra <= active_bank_wr ? '0 : wr_addr_next;
         bank0_dina  <= active_bank_wr ? '0 : wr_data_next;
         bank1_ena   <= wr_en_next && active_bank_wr;
         bank1_wea   <= wr_en_next && active_bank_wr;
         bank1_addra <= active_bank_wr ? wr_addr_next : '0;
         bank1_dina  <= active_bank_wr ? wr_data_next : '0;

         case (state)
            S_IDLE: begin
               if (accept) begin
                  data_sr <= in_data;
                  k       <= '0;
                  state   <= S_SER;
               end
            end
            S_SER: begin
               data_sr <= data_shifted;
               if (!last_slice) begin
                  k      <= k + 1'b1;
                  wr_ptr <= wr_ptr + 1'b1;
               end else if (bank_done) begin
                  k              <= '0;
                  wr_ptr         <= '0;
                  active_bank_wr <= other_bank;
                  state          <= full_next[other_bank] ? S_STALL : S_IDLE;
               end else begin
                  k      <= '0;
                  wr_ptr <= wr_ptr + 1'b1;
                  state  <= S_IDLE;
               end
            end
            S_STALL: begin
               // Leave one cycle after the bank we now own has been released.
               if (!bank_full[active_bank_wr]) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef PP_WR_ERR_CHECK_EN
   // valid_pending: in_valid was high last cycle without a handshake, so a
   // low in_valid now means the producer withdrew an offered beat.
   logic valid_pending;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err           <= 1'b0;
         valid_pending <= 1'b0;
      end else begin
         valid_pending <= in_valid && !in_ready;
         if (((rd_release & ~bank_full) != 2'b00) || (valid_pending && !in_valid)) begin
            err <= 1'b1;
         end
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

`default_nettype wire
